// File: rtl/booth_mult_unit.sv
// booth_mult_unit: multi-cycle signed 32x32 multiplier, radix-4 modified Booth.
// One 34-bit add/subtract per cycle, 16 iterations, then a single DONE cycle
// that writes the low product word, the overflow flag and a one-cycle ready.
// Optional macro MULT_EARLY_TERM_EN: a zero operand skips RUN and goes
// straight to DONE (result 0, latency 1, busy never asserted).
module booth_mult_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Accumulator is two bits wider than the operand so that -2M of the most
  // negative multiplicand is representable.
  localparam int AW = WIDTH + 2;
  // Product register: accumulator above the multiplier field, plus the
  // implicit zero bit below it that seeds the first Booth triplet.
  localparam int PW = AW + WIDTH + 1;
  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    m_q, m_d;
  logic        [PW-1:0]    p_q, p_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic        [WIDTH-1:0] result_q, result_d;
  logic                    exc_q, exc_d;
  logic                    rdy_q, rdy_d;
  logic        [AW-1:0]    sum;
  logic        [2*WIDTH-1:0] product;

  // One Booth step: recode the triplet and add 0, +-M or +-2M to the
  // accumulator; subtraction is inverted addend with carry-in 1.
  function automatic logic [AW-1:0] booth_step(input logic [AW-1:0] acc,
                                               input logic [AW-1:0] m,
                                               input logic [2:0]    code);
    logic [AW-1:0] mag;
    logic          sub;
    mag = '0;
    sub = 1'b0;
    case (code)
      3'b001, 3'b010: mag = m;
      3'b011:         mag = m << 1;
      3'b100:         begin mag = m << 1; sub = 1'b1; end
      3'b101, 3'b110: begin mag = m;      sub = 1'b1; end
      default:        mag = '0;
    endcase
    return acc + (sub ? ~mag : mag) + {{(AW-1){1'b0}}, sub};
  endfunction

  // Signed overflow of the low word: upper half must be the sign extension.
  function automatic logic low_word_overflows(input logic [2*WIDTH-1:0] prod);
    return prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  endfunction

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next state: a start pulse wins in every state and discards any operation
  // in flight, so an aborted multiply never reaches DONE.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    sum      = '0;
    product  = p_q[2*WIDTH:1];
    if (ctrl_MULT) begin
      m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      p_d     = {{AW{1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
      state_d = S_RUN;
`ifdef MULT_EARLY_TERM_EN
      if (data_operandA == '0 || data_operandB == '0) begin
        p_d     = '0;
        state_d = S_DONE;
      end
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          sum   = booth_step(p_q[PW-1:WIDTH+1], m_q, p_q[2:0]);
          p_d   = {{2{sum[AW-1]}}, sum, p_q[WIDTH:2]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_d = S_DONE;
        end
        S_DONE: begin
          result_d = product[WIDTH-1:0];
          exc_d    = low_word_overflows(product);
          rdy_d    = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == S_RUN);

endmodule
